mem_arb_ctrl: RTL

- Arbiter/sequencer that shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between the fetch/memory stages and the unified memory.
- Grants one requester at a time and holds the memory control/address stable for a fixed access latency.
- Returns read data with a one-cycle done pulse; the processor uses the inverted done signals as stalls.

---
 rtl/mem_arb_if.sv | 35 +++
 rtl/mem_arb_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of fetch, data and memory signals around the memory arbiter.
// Signals: i_req/i_addr (fetch request), d_rd/d_wr/d_addr/d_wdata (data request),
// halt, mem_rdata (memory return), mem_en/mem_wr/mem_addr/mem_wdata (memory control),
// i_rdata/i_done, d_rdata/d_done (completions), err (sticky protocol error).
// Modport master: requesters and memory side; modport slave: the arbiter.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          halt;
    logic [DW-1:0] mem_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          err;
    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, i_done, d_rdata, d_done, err
    );
    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, i_done, d_rdata, d_done, err
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: shares one single-ported memory between fetch and data stages.
// Ports: clk, rst (sync, active-high), bus (mem_arb_if.slave) carrying requests,
// memory control/data, registered read data, one-cycle done pulses and sticky err.
// Macro ARB_ROUND_ROBIN_EN: alternate grants when both requesters are pending;
// otherwise data always wins over fetch.
module mem_arb_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          own_q, own_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          d_req, f_req, gnt_data;
    assign d_req = bus.d_rd | bus.d_wr;
    assign f_req = bus.i_req & ~bus.halt;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // last_q=1 means data was granted last, so a contended grant goes to fetch
    assign gnt_data = d_req & (~f_req | ~last_q);
`else
    assign gnt_data = d_req;
`endif
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        if (state_q == IDLE) begin
            if (bus.d_rd && bus.d_wr)
                err_d = 1'b1;
            if (d_req || f_req) begin
                state_d = BUSY;
                own_d   = gnt_data;
                addr_d  = gnt_data ? bus.d_addr : bus.i_addr;
                wr_d    = gnt_data & bus.d_wr;
                wdata_d = bus.d_wdata;
                cnt_d   = 4'(MEM_LAT - 1);
`ifdef ARB_ROUND_ROBIN_EN
                last_d  = gnt_data;
`endif
            end
        end else if (state_q == BUSY) begin
            // the owner must hold its address for the whole access
            if (own_q ? (d_req && bus.d_addr != addr_q) : (bus.i_req && bus.i_addr != addr_q))
                err_d = 1'b1;
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                state_d = DONE;
                if (!wr_q) begin
                    if (own_q)
                        d_rdata_d = bus.mem_rdata;
                    else
                        i_rdata_d = bus.mem_rdata;
                end
            end
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_q     <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end
    assign bus.mem_en    = state_q == BUSY;
    assign bus.mem_wr    = (state_q == BUSY) & wr_q;
    assign bus.mem_addr  = (state_q == BUSY) ? addr_q : '0;
    assign bus.mem_wdata = (state_q == BUSY) ? wdata_q : '0;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_done    = (state_q == DONE) & ~own_q;
    assign bus.d_done    = (state_q == DONE) & own_q;
    assign bus.err       = err_q;
endmodule
